// File: rtl/writeback_if.sv
// writeback_if: MEM/WB stage inputs, data-memory response and register-file write port.
interface writeback_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
);
    logic              mem_valid;
    logic              mem_reg_write;
    logic [4:0]        mem_rd;
    logic [1:0]        mem_result_src;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_pc_plus4;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_stall;
    logic              we3;
    logic [4:0]        Addr3;
    logic [DATA_W-1:0] wd3;
    logic [CNT_W-1:0]  instret;

    modport master (
        output mem_valid, mem_reg_write, mem_rd, mem_result_src, mem_funct3,
               mem_alu_result, mem_pc_plus4, dmem_rvalid, dmem_rdata,
        input  wb_stall, we3, Addr3, wd3, instret
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_rd, mem_result_src, mem_funct3,
               mem_alu_result, mem_pc_plus4, dmem_rvalid, dmem_rdata,
        output wb_stall, we3, Addr3, wd3, instret
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register and load-wait sequencer driving the register-file write port.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) (
    input logic        clk,
    input logic        rst_n,
    writeback_if.slave wb
);
    typedef enum logic [1:0] {IDLE, EXEC, LWAIT} state_t;

    state_t            state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d, load_data;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    always_comb begin
        byte_v    = wb.dmem_rdata[{addr_q, 3'b000} +: 8];
        half_v    = addr_q[1] ? wb.dmem_rdata[31:16] : wb.dmem_rdata[15:0];
        load_data = (funct3_q == 3'b000) ? {{(DATA_W-8){byte_v[7]}}, byte_v} :
                    (funct3_q == 3'b100) ? {{(DATA_W-8){1'b0}}, byte_v} :
                    (funct3_q == 3'b001) ? {{(DATA_W-16){half_v[15]}}, half_v} :
                    (funct3_q == 3'b101) ? {{(DATA_W-16){1'b0}}, half_v} :
                    wb.dmem_rdata;
        state_d     = state_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        instret_d   = instret_q + CNT_W'(state_q == EXEC);
        if (state_q == LWAIT) begin
            if (wb.dmem_rvalid) begin
                wd_d    = load_data;
                state_d = EXEC;
            end
        end else if (wb.mem_valid) begin
            rd_d        = wb.mem_rd;
            reg_write_d = wb.mem_reg_write;
            funct3_d    = wb.mem_funct3;
            addr_d      = wb.mem_alu_result[1:0];
            if (wb.mem_result_src == 2'b01) begin
                state_d = LWAIT;
            end else begin
                wd_d    = (wb.mem_result_src == 2'b10) ? wb.mem_pc_plus4 : wb.mem_alu_result;
                state_d = EXEC;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wd_q        <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            instret_q   <= instret_d;
        end
    end

    // Outputs are pure register decodes so wd3 is stable over the falling commit edge.
    assign wb.wb_stall = (state_q == LWAIT);
    assign wb.we3      = (state_q == EXEC) && reg_write_q && (rd_q != 5'd0);
    assign wb.Addr3    = rd_q;
    assign wb.wd3      = wd_q;
    assign wb.instret  = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table-driven vectors plus directed multi-cycle sequences for writeback_stage.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_if #(.DATA_W(32), .CNT_W(64)) bus ();
    writeback_stage #(.DATA_W(32), .CNT_W(64)) dut (.clk(clk), .rst_n(rst_n), .wb(bus));

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
        int          lat;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    int checks = 0;
    int failures = 0;
    longint unsigned exp_instret = 0;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_valid      = 1'b0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_rd         = 5'd0;
        bus.mem_result_src = 2'b00;
        bus.mem_funct3     = 3'b000;
        bus.mem_alu_result = 32'h0;
        bus.mem_pc_plus4   = 32'h0;
        bus.dmem_rvalid    = 1'b0;
        bus.dmem_rdata     = 32'h0;
    endtask

    task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
        bus.mem_valid      = 1'b1;
        bus.mem_reg_write  = rw;
        bus.mem_rd         = rd;
        bus.mem_result_src = src;
        bus.mem_funct3     = f3;
        bus.mem_alu_result = alu;
        bus.mem_pc_plus4   = pc4;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v.rw, v.rd, v.src, v.f3, v.alu, v.pc4);
        @(posedge clk);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        for (int i = 1; i <= v.lat; i++) begin
            chk({tag, "_stall"}, 64'(bus.wb_stall), 64'd1);
            chk({tag, "_we_wait"}, 64'(bus.we3), 64'd0);
            bus.dmem_rvalid = (i == v.lat);
            bus.dmem_rdata  = v.rdata;
            @(posedge clk);
            @(negedge clk);
        end
        bus.dmem_rvalid = 1'b0;
        chk({tag, "_we"}, 64'(bus.we3), 64'(v.exp_we));
        chk({tag, "_nostall"}, 64'(bus.wb_stall), 64'd0);
        if (v.exp_we) chk({tag, "_addr"}, 64'(bus.Addr3), 64'(v.rd));
        if (v.exp_we) chk({tag, "_wd"}, 64'(bus.wd3), 64'(v.exp_wd));
        @(posedge clk);
        exp_instret++;
        @(negedge clk);
        chk({tag, "_instret"}, bus.instret, exp_instret);
        chk({tag, "_idle_we"}, 64'(bus.we3), 64'd0);
    endtask

    initial begin
        //          rw  rd     src    f3      alu            pc4           rdata          lat we  wd
        vecs[0]  = '{1'b1, 5'd5,  2'b00, 3'b000, 32'h0000_1234, 32'h0000_0004, 32'h0,         0, 1'b1, 32'h0000_1234};
        vecs[1]  = '{1'b1, 5'd6,  2'b01, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_7F01, 3, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 5'd6,  2'b01, 3'b100, 32'h0000_1003, 32'h0,         32'h80FF_7F01, 3, 1'b1, 32'h0000_0080};
        vecs[3]  = '{1'b1, 5'd8,  2'b01, 3'b001, 32'h0000_1002, 32'h0,         32'h80FF_7F01, 3, 1'b1, 32'hFFFF_80FF};
        vecs[4]  = '{1'b1, 5'd0,  2'b00, 3'b000, 32'h0000_0055, 32'h0,         32'h0,         0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  2'b10, 3'b000, 32'h0000_DEAD, 32'h0000_0104, 32'h0,         0, 1'b1, 32'h0000_0104};
        vecs[6]  = '{1'b1, 5'd10, 2'b01, 3'b010, 32'h0000_2000, 32'h0,         32'h1234_5678, 1, 1'b1, 32'h1234_5678};
        vecs[7]  = '{1'b1, 5'd11, 2'b01, 3'b101, 32'h0000_2003, 32'h0,         32'h80FF_7F01, 2, 1'b1, 32'h0000_80FF};
        vecs[8]  = '{1'b1, 5'd12, 2'b01, 3'b000, 32'h0000_2001, 32'h0,         32'h80FF_7F01, 1, 1'b1, 32'h0000_007F};
        vecs[9]  = '{1'b1, 5'd9,  2'b11, 3'b000, 32'h0000_A5A5, 32'h0000_0888, 32'h0,         0, 1'b1, 32'h0000_A5A5};
        vecs[10] = '{1'b1, 5'd0,  2'b01, 3'b000, 32'h0000_3000, 32'h0,         32'h0000_0001, 2, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd3,  2'b00, 3'b000, 32'h0000_0033, 32'h0,         32'h0,         0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 5'd13, 2'b01, 3'b011, 32'h0000_3001, 32'h0,         32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D};

        idle_inputs();
        #1;
        chk("rst_we", 64'(bus.we3), 64'd0);
        chk("rst_addr", 64'(bus.Addr3), 64'd0);
        chk("rst_wd", 64'(bus.wd3), 64'd0);
        chk("rst_stall", 64'(bus.wb_stall), 64'd0);
        chk("rst_instret", bus.instret, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // ALU, load waiting one cycle, PC+4 back to back
        @(negedge clk);
        drive(1'b1, 5'd1, 2'b00, 3'b000, 32'h0000_0011, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_alu_we", 64'(bus.we3), 64'd1);
        chk("b2b_alu_addr", 64'(bus.Addr3), 64'd1);
        chk("b2b_alu_wd", 64'(bus.wd3), 64'h11);
        drive(1'b1, 5'd2, 2'b01, 3'b010, 32'h0000_0020, 32'h0);
        @(posedge clk);
        exp_instret++;
        @(negedge clk);
        chk("b2b_ld_stall", 64'(bus.wb_stall), 64'd1);
        chk("b2b_ld_we", 64'(bus.we3), 64'd0);
        drive(1'b1, 5'd3, 2'b10, 3'b000, 32'h0000_0999, 32'h0000_0200);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hCAFE_BABE;
        @(posedge clk);
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        chk("b2b_ld_wr_we", 64'(bus.we3), 64'd1);
        chk("b2b_ld_wr_addr", 64'(bus.Addr3), 64'd2);
        chk("b2b_ld_wr_wd", 64'(bus.wd3), 64'hCAFE_BABE);
        chk("b2b_ld_wr_stall", 64'(bus.wb_stall), 64'd0);
        @(posedge clk);
        exp_instret++;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("b2b_pc_we", 64'(bus.we3), 64'd1);
        chk("b2b_pc_addr", 64'(bus.Addr3), 64'd3);
        chk("b2b_pc_wd", 64'(bus.wd3), 64'h200);
        @(posedge clk);
        exp_instret++;
        @(negedge clk);
        chk("b2b_instret", bus.instret, exp_instret);

        // rvalid while idle and while in EXEC must be ignored
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("spur_idle_we", 64'(bus.we3), 64'd0);
        chk("spur_idle_wd", 64'(bus.wd3), 64'h200);
        chk("spur_idle_stall", 64'(bus.wb_stall), 64'd0);
        bus.dmem_rvalid = 1'b0;
        drive(1'b1, 5'd4, 2'b00, 3'b000, 32'h0000_0044, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.mem_valid   = 1'b0;
        bus.dmem_rvalid = 1'b1;
        chk("spur_exec_we", 64'(bus.we3), 64'd1);
        @(posedge clk);
        exp_instret++;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        chk("spur_exec_we_after", 64'(bus.we3), 64'd0);
        chk("spur_exec_wd", 64'(bus.wd3), 64'h44);
        chk("spur_exec_stall", 64'(bus.wb_stall), 64'd0);
        chk("spur_instret", bus.instret, exp_instret);

        // asynchronous reset while a load is pending
        drive(1'b1, 5'd14, 2'b01, 3'b000, 32'h0000_4000, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("rml_stall", 64'(bus.wb_stall), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rml_we", 64'(bus.we3), 64'd0);
        chk("rml_addr", 64'(bus.Addr3), 64'd0);
        chk("rml_wd", 64'(bus.wd3), 64'd0);
        chk("rml_stall0", 64'(bus.wb_stall), 64'd0);
        chk("rml_instret", bus.instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        chk("rml_post_we", 64'(bus.we3), 64'd0);
        chk("rml_post_stall", 64'(bus.wb_stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rml_post_we2", 64'(bus.we3), 64'd0);
        chk("rml_post_wd", 64'(bus.wd3), 64'd0);
        chk("rml_post_instret", bus.instret, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
